// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl
// ---------------
// Parametrised pipeline-register bank with hazard control for the RV32 core.
// Each of the STAGES register stages holds a WIDTH-bit payload and a valid bit.
// The payload is opaque here; the datapath packs control and data into it.
//
// Hazard handling (first matching rule wins, per stage k):
//   flush && k < FLUSH_DEPTH -> bubble (overrides stall and hold)
//   stall                    -> hold contents
//   hold  && k == 0          -> hold contents (load-use: keep the consumer)
//   hold  && k == 1          -> bubble (the gap behind the held instruction)
//   otherwise                -> load from stage k-1 (stage 0 loads the input)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears all state
//   stall        cache stall, freezes every stage not being flushed
//   hold         load-use hazard
//   flush        taken branch/jump, clears stages 0..FLUSH_DEPTH-1
//   in_valid     fetch payload valid
//   in_data      fetch payload
//   in_ready     combinational: !stall && !hold && !flush
//   stage_valid  valid bit of each stage (bit k = stage k)
//   stage_data   payload of each stage (stage k at [k*WIDTH +: WIDTH])
//   out_valid    valid bit of the last stage
//   out_data     payload of the last stage
//   occupancy    combinational count of valid stages
//   retire_cnt   saturating count of cycles retiring a valid payload
//   bubble_cnt   saturating count of cycles with an empty last stage

module pipe_stage_ctrl #(
  parameter int WIDTH       = 32,
  parameter int STAGES      = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         hold,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic [STAGES-1:0]            stage_valid,
  output logic [STAGES*WIDTH-1:0]      stage_data,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [CNT_W-1:0]             bubble_cnt
);

  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [CNT_W-1:0]  retire_q, retire_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  // Last stage is consumed on every non-stalled edge.
  logic consume;
  assign consume = !stall;

  // ---------------------------------------------------------------------------
  // Next-state for the register stages
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every stage defaults to its current value so no path through the
    // priority chain leaves a variable unassigned and infers a latch.
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      data_d[k] = data_q[k];
    end

    // Stage 0: flush beats stall beats hold; otherwise take the fetch input.
    if (flush) begin
      valid_d[0] = 1'b0;
      data_d[0]  = '0;
    end else if (stall || hold) begin
      valid_d[0] = valid_q[0];
    end else begin
      valid_d[0] = in_valid;
      data_d[0]  = in_data;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (flush && (k < FLUSH_DEPTH)) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end else if (stall) begin
        valid_d[k] = valid_q[k];
      end else if (hold && (k == 1)) begin
        // Load-use bubble: stage 0 is held, so stage 1 must not duplicate it.
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
      end else begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (consume) begin
      if (valid_q[STAGES-1]) begin
        if (retire_q != '1) retire_d = retire_q + 1'b1;
      end else begin
        if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      retire_q <= '0;
      bubble_q <= '0;
      // NOTE: the payload bank is ordinary flops (not a RAM), so it is reset
      // too; bubbles are defined to carry payload 0.
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge
      // value of its neighbour, giving a true shift rather than a ripple.
      valid_q  <= valid_d;
      retire_q <= retire_d;
      bubble_q <= bubble_d;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = !stall && !hold && !flush;
  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign retire_cnt  = retire_q;
  assign bubble_cnt  = bubble_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl (STAGES=3, WIDTH=8, CNT_W=4).
// A main instance uses FLUSH_DEPTH=2; a second instance with FLUSH_DEPTH=1
// shares the inputs to cover flush combined with hold on a shallow flush.

module tb_pipe_stage_ctrl;

  localparam int W = 8;
  localparam int S = 3;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset, stall, hold, flush, in_valid;
  logic [W-1:0] in_data;

  logic           in_ready;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     occupancy;
  logic [C-1:0]   retire_cnt, bubble_cnt;

  logic           f1_in_ready;
  logic [S-1:0]   f1_stage_valid;
  logic [S*W-1:0] f1_stage_data;
  logic           f1_out_valid;
  logic [W-1:0]   f1_out_data;
  logic [1:0]     f1_occupancy;
  logic [C-1:0]   f1_retire_cnt, f1_bubble_cnt;

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.WIDTH(W), .STAGES(S), .FLUSH_DEPTH(2), .CNT_W(C)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy),
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_ctrl #(.WIDTH(W), .STAGES(S), .FLUSH_DEPTH(1), .CNT_W(C)) u_fd1 (
    .clk(clk), .reset(reset), .stall(stall), .hold(hold), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(f1_in_ready),
    .stage_valid(f1_stage_valid), .stage_data(f1_stage_data),
    .out_valid(f1_out_valid), .out_data(f1_out_data), .occupancy(f1_occupancy),
    .retire_cnt(f1_retire_cnt), .bubble_cnt(f1_bubble_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic ho, input logic fl,
                       input logic iv, input logic [W-1:0] id);
    stall = st; hold = ho; flush = fl; in_valid = iv; in_data = id;
  endtask

  // One row: inputs applied before an edge, expected state just after it.
  // ed is packed {stage2, stage1, stage0}.
  typedef struct {
    logic         st, ho, fl, iv;
    logic [W-1:0] id;
    logic [S-1:0] ev;
    logic [23:0]  ed;
    logic [C-1:0] er, eb;
    logic         rdy;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ho, input logic fl,
                              input logic iv, input logic [W-1:0] id,
                              input logic [S-1:0] ev, input logic [23:0] ed,
                              input logic [C-1:0] er, input logic [C-1:0] eb,
                              input logic rdy);
    vec_t v;
    v.st = st; v.ho = ho; v.fl = fl; v.iv = iv; v.id = id;
    v.ev = ev; v.ed = ed; v.er = er; v.eb = eb; v.rdy = rdy;
    return v;
  endfunction

  vec_t vecs[31];

  initial begin
    // Stream 0x11/0x22/0x33
    vecs[0]  = mk(0,0,0,1,8'h11, 3'b001, 24'h000011, 0, 1, 1);
    vecs[1]  = mk(0,0,0,1,8'h22, 3'b011, 24'h001122, 0, 2, 1);
    vecs[2]  = mk(0,0,0,1,8'h33, 3'b111, 24'h112233, 0, 3, 1);
    vecs[3]  = mk(0,0,0,0,8'h00, 3'b110, 24'h223300, 1, 3, 1);
    vecs[4]  = mk(0,0,0,0,8'h00, 3'b100, 24'h330000, 2, 3, 1);
    vecs[5]  = mk(0,0,0,0,8'h00, 3'b000, 24'h000000, 3, 3, 1);
    // Stall 4 cycles with 0xA0 in stage 1; offered input must be ignored
    vecs[6]  = mk(0,0,0,1,8'hA0, 3'b001, 24'h0000A0, 3, 4, 1);
    vecs[7]  = mk(0,0,0,0,8'h00, 3'b010, 24'h00A000, 3, 5, 1);
    vecs[8]  = mk(1,0,0,1,8'hFF, 3'b010, 24'h00A000, 3, 5, 0);
    vecs[9]  = mk(1,0,0,1,8'hFF, 3'b010, 24'h00A000, 3, 5, 0);
    vecs[10] = mk(1,0,0,1,8'hFF, 3'b010, 24'h00A000, 3, 5, 0);
    vecs[11] = mk(1,0,0,1,8'hFF, 3'b010, 24'h00A000, 3, 5, 0);
    vecs[12] = mk(0,0,0,0,8'h00, 3'b100, 24'hA00000, 3, 6, 1);
    vecs[13] = mk(0,0,0,0,8'h00, 3'b000, 24'h000000, 4, 6, 1);
    // Load-use hold: stage0=0xB0, stage1=0xC0
    vecs[14] = mk(0,0,0,1,8'hC0, 3'b001, 24'h0000C0, 4, 7, 1);
    vecs[15] = mk(0,0,0,1,8'hB0, 3'b011, 24'h00C0B0, 4, 8, 1);
    vecs[16] = mk(0,1,0,1,8'hEE, 3'b101, 24'hC000B0, 4, 9, 0);
    vecs[17] = mk(0,0,0,0,8'h00, 3'b010, 24'h00B000, 5, 9, 1);
    vecs[18] = mk(0,0,0,0,8'h00, 3'b100, 24'hB00000, 5,10, 1);
    vecs[19] = mk(0,0,0,0,8'h00, 3'b000, 24'h000000, 6,10, 1);
    // Flush with stages 0x1/0x2/0x3
    vecs[20] = mk(0,0,0,1,8'h03, 3'b001, 24'h000003, 6,11, 1);
    vecs[21] = mk(0,0,0,1,8'h02, 3'b011, 24'h000302, 6,12, 1);
    vecs[22] = mk(0,0,0,1,8'h01, 3'b111, 24'h030201, 6,13, 1);
    vecs[23] = mk(0,0,1,1,8'h77, 3'b100, 24'h020000, 7,13, 0);
    vecs[24] = mk(0,0,0,0,8'h00, 3'b000, 24'h000000, 8,13, 1);
    // Flush+stall; bubble_cnt saturates at 0xF along the way
    vecs[25] = mk(0,0,0,1,8'h05, 3'b001, 24'h000005, 8,14, 1);
    vecs[26] = mk(0,0,0,1,8'h06, 3'b011, 24'h000506, 8,15, 1);
    vecs[27] = mk(0,0,0,1,8'h07, 3'b111, 24'h050607, 8,15, 1);
    vecs[28] = mk(1,0,1,0,8'h00, 3'b100, 24'h050000, 8,15, 0);
    vecs[29] = mk(1,0,0,0,8'h00, 3'b100, 24'h050000, 8,15, 0);
    vecs[30] = mk(0,0,0,0,8'h00, 3'b000, 24'h000000, 9,15, 1);

    // Reset state, checked before any clock edge
    reset = 1'b0;
    drive(0,0,0,0,8'h00);
    #2;
    check("rst stage_valid", 32'(stage_valid), 32'h0);
    check("rst stage_data",  32'(stage_data),  32'h0);
    check("rst occupancy",   32'(occupancy),   32'h0);
    check("rst retire_cnt",  32'(retire_cnt),  32'h0);
    check("rst bubble_cnt",  32'(bubble_cnt),  32'h0);
    #10 reset = 1'b1;   // released at t=12, between edges

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].st, vecs[i].ho, vecs[i].fl, vecs[i].iv, vecs[i].id);
      step();
      check($sformatf("row%0d stage_valid", i), 32'(stage_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d stage_data",  i), 32'(stage_data),  32'(vecs[i].ed));
      check($sformatf("row%0d out_valid",   i), 32'(out_valid),   32'(vecs[i].ev[2]));
      check($sformatf("row%0d out_data",    i), 32'(out_data),    32'(vecs[i].ed[23:16]));
      check($sformatf("row%0d occupancy",   i), 32'(occupancy),   32'($countones(vecs[i].ev)));
      check($sformatf("row%0d retire_cnt",  i), 32'(retire_cnt),  32'(vecs[i].er));
      check($sformatf("row%0d bubble_cnt",  i), 32'(bubble_cnt),  32'(vecs[i].eb));
      check($sformatf("row%0d in_ready",    i), 32'(in_ready),    32'(vecs[i].rdy));
    end

    // Flush+hold: FLUSH_DEPTH=1 instance still bubbles stage 1 under hold,
    // FLUSH_DEPTH=2 instance clears stages 0 and 1 through flush.
    drive(0,0,0,1,8'h81); step();
    drive(0,0,0,1,8'h82); step();
    drive(0,1,1,1,8'h83); step();
    check("fd1 stage_valid", 32'(f1_stage_valid), 32'h4);
    check("fd1 stage_data",  32'(f1_stage_data),  32'h810000);
    check("fd2 stage_valid", 32'(stage_valid),    32'h4);
    check("fd2 out_data",    32'(out_data),       32'h81);

    // Saturation: 20 more valid payloads push retire_cnt past 0xF
    for (int i = 0; i < 20; i++) begin
      drive(0,0,0,1,8'(i + 1));
      step();
    end
    check("sat retire_cnt (pipe full)", 32'(retire_cnt), 32'hF);
    check("sat bubble_cnt",             32'(bubble_cnt), 32'hF);
    drive(0,0,0,0,8'h00);
    step();
    check("sat retire_cnt (stuck)",     32'(retire_cnt), 32'hF);
    check("sat pipe still full",        32'(stage_valid), 32'h6);

    // Asynchronous reset between edges, no clock edge needed
    #3 reset = 1'b0;
    #1;
    check("async rst stage_valid", 32'(stage_valid), 32'h0);
    check("async rst stage_data",  32'(stage_data),  32'h0);
    check("async rst out_valid",   32'(out_valid),   32'h0);
    check("async rst out_data",    32'(out_data),    32'h0);
    check("async rst occupancy",   32'(occupancy),   32'h0);
    check("async rst retire_cnt",  32'(retire_cnt),  32'h0);
    check("async rst bubble_cnt",  32'(bubble_cnt),  32'h0);
    #2 reset = 1'b1;

    // First payload is accepted at the first edge after reset release
    drive(0,0,0,1,8'h5A);
    step();
    check("post rst stage_valid", 32'(stage_valid), 32'h1);
    check("post rst stage_data",  32'(stage_data),  32'h00005A);
    check("post rst bubble_cnt",  32'(bubble_cnt),  32'h1);
    check("post rst retire_cnt",  32'(retire_cnt),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
# pipe_stage_ctrl

Parametrised pipeline-register bank and hazard controller for the RV32 core: STAGES payload registers with per-stage valid bits and a global cache stall. It also provides load-use bubble insertion, branch flush of the front stages, and retire/bubble performance counters. It replaces the hand-instantiated fixed 3-stage pipeline registers between fetch, execute and writeback. The core's datapath packs each stage's control and data fields into the WIDTH-bit payload.

## Interface
Parameters:
- WIDTH, 32, payload bits per stage
- STAGES, 3, number of register stages (legal 2..8)
- FLUSH_DEPTH, 2, number of front stages cleared by flush (legal 1..STAGES)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; asserting it (low) clears all state immediately
- stall  in  1  cache stall; freezes every stage not being flushed
- hold  in  1  load-use hazard; stage 0 holds, stage 1 receives a bubble, stages ≥2 advance
- flush  in  1  taken branch/jump; clears stages 0..FLUSH_DEPTH-1
- in_valid  in  1  fetch payload valid
- in_data  in  WIDTH  fetch payload
- in_ready  out  1  = !stall && !hold && !flush; in_data is accepted only when in_valid && in_ready
- stage_valid  out  STAGES  valid bit of each stage, bit k = stage k
- stage_data  out  STAGES*WIDTH  payload of each stage, stage k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  = stage_valid[STAGES-1]
- out_data  out  WIDTH  = payload of stage STAGES-1
- occupancy  out  $clog2(STAGES+1)  count of set stage_valid bits (combinational)
- retire_cnt  out  CNT_W  instructions retired
- bubble_cnt  out  CNT_W  empty cycles at the last stage

## Operation
- Reset (low): all valid=0, all payload=0, retire_cnt=0, bubble_cnt=0. The reset value of occupancy therefore reads 0.
- Bubble and flushed stages always load payload 0 with valid 0.
- Per-edge update for stage k. The first matching rule applies:
  1. flush && k<FLUSH_DEPTH: stage k becomes a bubble, regardless of stall or hold.
  2. stall: stage k holds.
  3. hold && k==0: stage 0 holds.
  4. hold && k==1: stage 1 becomes a bubble.
  5. Otherwise stage k loads from stage k-1. Stage 0 loads {in_valid, in_data}.
- Flush with hold: a flush overrides hold for the flushed stages. Stages ≥FLUSH_DEPTH follow rules 2-5.
  - When FLUSH_DEPTH==1 and hold is asserted, stage 1 still receives a bubble.
- The last stage's contents are consumed every cycle that stall=0.
  - retire_cnt increments when stall=0 && out_valid=1.
  - bubble_cnt increments when stall=0 && out_valid=0.
  - Neither counter changes while stall=1.
  - Both counters saturate at all-ones and never wrap.
- The block does not inspect the payload. Hazard detection and forwarding select stay in the datapath.

## Timing
- Latency: with stall=hold=flush=0, a payload accepted at edge N appears on out_data/out_valid after edge N+STAGES-1. It is visible for exactly one cycle.
- All outputs except in_ready and occupancy are registered. in_ready and occupancy are combinational.
- stall is sampled at the same edge it gates, so a one-cycle stall pulse delays the whole pipe by exactly one cycle.
- When hold is held for H cycles, stage 0 is frozen H cycles and H bubbles are inserted behind it.
- flush takes effect at the next edge. Flushed stages read valid=0 in the following cycle.
- Simultaneous flush+stall: flushed stages clear and the remaining stages freeze. No payload is lost from the unflushed stages.
- Reset mid-operation: state clears asynchronously with no clock needed. The first payload is accepted at the first edge after reset deasserts.

## Test plan
- Stream, STAGES=3: push payloads 0x11, 0x22, 0x33 on consecutive edges with no stall. out_data shows 0x11/0x22/0x33 on the 3rd/4th/5th cycles, retire_cnt=3, and the count of leading bubble cycles matches bubble_cnt.
- Stall: with 0xA0 in stage 1, hold stall=1 for 4 cycles. stage_data stays constant, both counters stay frozen and in_ready=0. 0xA0 exits exactly 4 cycles later than in the unstalled run.
- Load-use hold: stage0=0xB0, stage1=0xC0, pulse hold for one cycle. Next cycle: stage0=0xB0, stage1=bubble, stage2=0xC0. 0xB0 retires one cycle late, and bubble_cnt increments once for the injected gap.
- Flush, FLUSH_DEPTH=2: stages hold 0x1/0x2/0x3 when flush pulses. Next cycle stage0=stage1=0 with valid 0; 0x2 reaches the last stage from stage 1 and 0x3 retires; retire_cnt increments once for 0x3.
- Flush+stall together: stages 0 and 1 clear, and the last stage keeps its payload and valid until stall drops.
- Saturation and reset: with CNT_W=4, run 20 valid retirements. retire_cnt sticks at 0xF. Assert reset (low) asynchronously between edges: all outputs go to 0 immediately.
